// File: rtl/rs_pkg.sv
// Shared sizing and entry-state encoding for the reservation-station issue scheduler.
package rs_pkg;
  localparam int NUM_ENT = 8;
  localparam int TAG_W   = 4;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_GRANT} ent_st_e;
endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks allocation order of live entries and picks the oldest READY one.
module rs_age_matrix #(
  parameter int NUM_ENT = rs_pkg::NUM_ENT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [rs_pkg::IDX_W-1:0] alloc_idx,
  input  logic [NUM_ENT-1:0]       busy,
  input  logic                     free_en,
  input  logic [rs_pkg::IDX_W-1:0] free_idx,
  input  logic [NUM_ENT-1:0]       ready,
  output logic                     cand_valid,
  output logic [rs_pkg::IDX_W-1:0] cand_idx
);
  import rs_pkg::*;

  // older_q[i][j] set means entry j was allocated before entry i
  logic [NUM_ENT-1:0][NUM_ENT-1:0] older_q;
  logic [NUM_ENT-1:0]              cand;

  always_comb begin
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < NUM_ENT; i++)
      cand[i] = ready[i] & ~|(older_q[i] & ready);
    for (int i = NUM_ENT-1; i >= 0; i--)
      if (cand[i]) cand_idx = IDX_W'(i);
  end
  assign cand_valid = |cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_q <= '0;
    end else if (flush) begin
      older_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++)
        for (int j = 0; j < NUM_ENT; j++)
          // freeing wins over a same-cycle allocation that saw the entry as busy
          if (free_en && (free_idx == IDX_W'(i) || free_idx == IDX_W'(j)))
            older_q[i][j] <= 1'b0;
          else if (alloc_en && alloc_idx == IDX_W'(i))
            older_q[i][j] <= busy[j];
    end
  end
endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station scheduler: allocation, CDB wakeup, oldest-ready select, registered grant.
module rs_issue_sched #(
  parameter int NUM_ENT = rs_pkg::NUM_ENT,
  parameter int TAG_W   = rs_pkg::TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [TAG_W-1:0]         alloc_tag1,
  input  logic [TAG_W-1:0]         alloc_tag2,
  input  logic                     alloc_rdy1,
  input  logic                     alloc_rdy2,
  output logic                     avail,
  output logic [rs_pkg::IDX_W-1:0] alloc_idx,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  output logic                     issue_valid,
  output logic [rs_pkg::IDX_W-1:0] issue_idx,
  input  logic                     issue_ready,
  input  logic                     flush,
  output logic [3:0]               count
);
  import rs_pkg::*;

  ent_st_e [NUM_ENT-1:0]            st_q;
  logic    [NUM_ENT-1:0]            w1_q, w2_q, w1_nx, w2_nx;
  logic    [NUM_ENT-1:0][TAG_W-1:0] t1_q, t2_q;
  logic    [NUM_ENT-1:0]            free_v, rdy_v;
  logic                             cand_vld, fire, load, alloc_en, byp1, byp2;
  logic    [IDX_W-1:0]              cand_idx;

  always_comb begin
    free_v    = '0;
    rdy_v     = '0;
    w1_nx     = '0;
    w2_nx     = '0;
    alloc_idx = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      free_v[i] = (st_q[i] == ST_FREE);
      rdy_v[i]  = (st_q[i] == ST_READY);
      w1_nx[i]  = w1_q[i] & ~(cdb_valid && t1_q[i] == cdb_tag);
      w2_nx[i]  = w2_q[i] & ~(cdb_valid && t2_q[i] == cdb_tag);
    end
    for (int i = NUM_ENT-1; i >= 0; i--)
      if (free_v[i]) alloc_idx = IDX_W'(i);
  end

  assign avail    = |free_v;
  assign count    = 4'($countones(~free_v));
  assign fire     = issue_valid & issue_ready;
  assign load     = ~issue_valid | issue_ready;
  assign alloc_en = alloc_valid & avail;
  // same-cycle CDB result counts as already available
  assign byp1     = alloc_rdy1 | (cdb_valid && cdb_tag == alloc_tag1);
  assign byp2     = alloc_rdy2 | (cdb_valid && cdb_tag == alloc_tag2);

  rs_age_matrix #(.NUM_ENT(NUM_ENT)) u_age (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_en   (alloc_en),
    .alloc_idx  (alloc_idx),
    .busy       (~free_v),
    .free_en    (fire),
    .free_idx   (issue_idx),
    .ready      (rdy_v),
    .cand_valid (cand_vld),
    .cand_idx   (cand_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= {NUM_ENT{ST_FREE}};
      w1_q        <= '0;
      w2_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      issue_valid <= 1'b0;
      issue_idx   <= '0;
    end else if (flush) begin
      st_q        <= {NUM_ENT{ST_FREE}};
      w1_q        <= '0;
      w2_q        <= '0;
      issue_valid <= 1'b0;
      issue_idx   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        w1_q[i] <= w1_nx[i];
        w2_q[i] <= w2_nx[i];
        if (st_q[i] == ST_WAIT && !w1_nx[i] && !w2_nx[i]) st_q[i] <= ST_READY;
        if (load && cand_vld && cand_idx == IDX_W'(i))    st_q[i] <= ST_GRANT;
        if (fire && issue_idx == IDX_W'(i))               st_q[i] <= ST_FREE;
        if (alloc_en && alloc_idx == IDX_W'(i)) begin
          st_q[i] <= (byp1 && byp2) ? ST_READY : ST_WAIT;
          w1_q[i] <= ~byp1;
          w2_q[i] <= ~byp2;
          t1_q[i] <= alloc_tag1;
          t2_q[i] <= alloc_tag2;
        end
      end
      if (load) begin
        issue_valid <= cand_vld;
        if (cand_vld) issue_idx <= cand_idx;
      end
    end
  end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed vector table, corner sequences, random run vs. a timestamp model.
module tb_rs_issue_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0, alloc_rdy1 = 1'b0, alloc_rdy2 = 1'b0;
  logic [3:0] alloc_tag1 = '0, alloc_tag2 = '0, cdb_tag = '0;
  logic       cdb_valid = 1'b0, issue_ready = 1'b0, flush = 1'b0;
  logic       avail, issue_valid;
  logic [2:0] alloc_idx, issue_idx;
  logic [3:0] count;

  int total = 0;
  int bad = 0;

  rs_issue_sched #(.NUM_ENT(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_tag1(alloc_tag1),
    .alloc_tag2(alloc_tag2), .alloc_rdy1(alloc_rdy1), .alloc_rdy2(alloc_rdy2),
    .avail(avail), .alloc_idx(alloc_idx), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int av, t1, t2, r1, r2, cv, ct, ir, fl;
    int e_avail, e_aidx, e_cnt, e_iv, e_ii;
  } vec_t;
  vec_t vq[$];

  // Reference model: entry state 0=free 1=wait 2=ready 3=granted; age is an alloc timestamp
  int m_st[8], m_t1[8], m_t2[8], m_age[8];
  bit m_w1[8], m_w2[8];
  int m_seq, m_ii;
  bit m_iv;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input int e_av, input int e_aidx,
                         input int e_cnt, input int e_iv, input int e_ii);
    chk({name, ".avail"}, int'(avail), e_av);
    chk({name, ".alloc_idx"}, int'(alloc_idx), e_aidx);
    chk({name, ".count"}, int'(count), e_cnt);
    chk({name, ".issue_valid"}, int'(issue_valid), e_iv);
    if (e_iv != 0) chk({name, ".issue_idx"}, int'(issue_idx), e_ii);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin m_st[i] = 0; m_w1[i] = 0; m_w2[i] = 0; end
    m_iv = 0; m_ii = 0; m_seq = 0;
  endtask

  task automatic m_step(input vec_t v);
    int lf, cand;
    bit fire, load, b1, b2;
    if (v.fl != 0) begin
      for (int i = 0; i < 8; i++) m_st[i] = 0;
      m_iv = 0; m_ii = 0;
      return;
    end
    lf = -1; cand = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_st[i] == 0 && lf < 0) lf = i;
      if (m_st[i] == 2 && (cand < 0 || m_age[i] < m_age[cand])) cand = i;
    end
    fire = m_iv && (v.ir != 0);
    load = !m_iv || (v.ir != 0);
    for (int i = 0; i < 8; i++)
      if (m_st[i] == 1 && v.cv != 0) begin
        if (m_t1[i] == v.ct) m_w1[i] = 0;
        if (m_t2[i] == v.ct) m_w2[i] = 0;
        if (!m_w1[i] && !m_w2[i]) m_st[i] = 2;
      end
    if (fire) m_st[m_ii] = 0;
    if (load) begin
      m_iv = (cand >= 0);
      if (cand >= 0) begin m_st[cand] = 3; m_ii = cand; end
    end
    if (v.av != 0 && lf >= 0) begin
      b1 = (v.r1 != 0) || (v.cv != 0 && v.ct == v.t1);
      b2 = (v.r2 != 0) || (v.cv != 0 && v.ct == v.t2);
      m_st[lf] = (b1 && b2) ? 2 : 1;
      m_w1[lf] = !b1; m_w2[lf] = !b2;
      m_t1[lf] = v.t1; m_t2[lf] = v.t2;
      m_age[lf] = m_seq++;
    end
  endtask

  task automatic drive(input vec_t v);
    alloc_valid = v.av[0]; alloc_tag1 = v.t1[3:0]; alloc_tag2 = v.t2[3:0];
    alloc_rdy1 = v.r1[0]; alloc_rdy2 = v.r2[0]; cdb_valid = v.cv[0];
    cdb_tag = v.ct[3:0]; issue_ready = v.ir[0]; flush = v.fl[0];
  endtask

  function automatic vec_t mk(int av, int t1, int t2, int r1, int r2, int cv, int ct,
                              int ir, int fl, int ea, int ei, int ec, int ev, int eii);
    vec_t v;
    v.av = av; v.t1 = t1; v.t2 = t2; v.r1 = r1; v.r2 = r2; v.cv = cv; v.ct = ct;
    v.ir = ir; v.fl = fl; v.e_avail = ea; v.e_aidx = ei; v.e_cnt = ec; v.e_iv = ev; v.e_ii = eii;
    return v;
  endfunction

  task automatic step(input vec_t v);
    drive(v);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  int m_cnt, m_lf;
  vec_t rv;

  initial begin
    // reset state while rst is held
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 1, 0, 0, 0, 0);
    chk("reset.issue_idx", int'(issue_idx), 0);
    rst = 1'b0;

    // directed table: latency, bypass, oldest-first, hold while stalled
    vq.push_back(mk(1,1,2,1,1,0,0,0,0, 1,1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,1,1,0));
    vq.push_back(mk(1,7,3,0,1,1,7,0,0, 1,2,2,1,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1,0, 1,0,1,1,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1,0, 1,0,0,0,0));
    vq.push_back(mk(1,5,0,0,1,0,0,0,0, 1,1,1,0,0));
    vq.push_back(mk(1,1,2,1,1,0,0,0,0, 1,2,2,0,0));
    vq.push_back(mk(0,0,0,0,0,1,5,0,0, 1,2,2,1,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 1,2,2,1,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 1,2,2,1,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1,0, 1,1,1,1,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1,0, 1,0,0,0,0));
    foreach (vq[k]) begin
      step(vq[k]);
      chk_out($sformatf("vec%0d", k), vq[k].e_avail, vq[k].e_aidx, vq[k].e_cnt,
              vq[k].e_iv, vq[k].e_ii);
    end

    // fill all entries, overflow alloc ignored, one handshake frees one entry
    do_reset();
    for (int i = 0; i < 8; i++) step(mk(1,i,i,1,1,0,0,0,0, 0,0,0,0,0));
    chk_out("full", 0, 0, 8, 1, 0);
    step(mk(1,3,3,1,1,0,0,0,0, 0,0,0,0,0));
    chk_out("overflow", 0, 0, 8, 1, 0);
    step(mk(1,3,3,1,1,0,0,1,0, 0,0,0,0,0));
    chk_out("free_one", 1, 0, 7, 1, 1);

    // flush with 5 entries and a live grant, alloc/issue asserted alongside
    do_reset();
    for (int i = 0; i < 5; i++) step(mk(1,i,i,1,1,0,0,0,0, 0,0,0,0,0));
    chk_out("pre_flush", 1, 5, 5, 1, 0);
    step(mk(1,2,2,1,1,1,2,1,1, 0,0,0,0,0));
    chk_out("flush", 1, 0, 0, 0, 0);

    // async reset mid-handshake drops outputs without a clock edge
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < 3; i++) step(mk(1,i,i,1,1,0,0,0,0, 0,0,0,0,0));
    issue_ready = 1'b1;
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 1, 0, 0, 0, 0);
    chk("async_rst.issue_idx", int'(issue_idx), 0);
    @(posedge clk); #1 rst = 1'b0;
    m_reset();

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      rv = mk(($urandom_range(99) < 60) ? 1 : 0, int'($urandom_range(15)),
              int'($urandom_range(15)), int'($urandom_range(1)), int'($urandom_range(1)),
              int'($urandom_range(1)), int'($urandom_range(15)),
              ($urandom_range(99) < 55) ? 1 : 0, ($urandom_range(99) < 2) ? 1 : 0,
              0,0,0,0,0);
      m_step(rv);
      step(rv);
      m_cnt = 0; m_lf = -1;
      for (int i = 0; i < 8; i++)
        if (m_st[i] == 0) begin if (m_lf < 0) m_lf = i; end
        else m_cnt++;
      chk_out($sformatf("rand%0d", c), (m_lf >= 0) ? 1 : 0, (m_lf >= 0) ? m_lf : 0,
              m_cnt, int'(m_iv), m_ii);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
